// File: rtl/alu64bit_wb.sv
// Write-back stage for alu64bit: derives Z/N/C/V from the result and holds up to two entries in a skid FIFO.
// Define ALU64BIT_WB_STICKY_EN to add the sticky carry/overflow accumulator (clr_sticky / sticky ports).
module alu64bit_wb #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
`ifdef ALU64BIT_WB_STICKY_EN
    ,
    input  logic             clr_sticky,
    output logic [1:0]       sticky
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready depends only on registered count and rst, never on out_ready.
    logic [WIDTH-1:0] mem_res [DEPTH];
    logic [3:0]       mem_flg [DEPTH];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;
    logic [3:0]       new_flags;
    logic             v_bit;
    logic             a_m;
    logic             b_m;
    logic             s_m;

    // Only the sign bits of the operands are needed for overflow.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a[WIDTH-2:0], b[WIDTH-2:0]};

    assign a_m = a[WIDTH-1];
    assign b_m = b[WIDTH-1];
    assign s_m = s[WIDTH-1];

    always_comb begin
        v_bit = 1'b0;
        case (op)
            2'b10:   v_bit = (a_m == b_m) & (s_m != a_m);
            2'b11:   v_bit = (a_m != b_m) & (s_m != a_m);
            default: v_bit = 1'b0;
        endcase
    end

    assign new_flags = {(s == '0), s_m, op[1] & cout, v_bit};

    assign in_ready  = (count < FULL) & ~rst;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign res       = mem_res[rd_ptr];
    assign flags     = mem_flg[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_res[i] <= '0;
                mem_flg[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_res[wr_ptr] <= s;
                mem_flg[wr_ptr] <= new_flags;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU64BIT_WB_STICKY_EN
    // Accumulates C and V of entries as they leave; a clear takes priority over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || clr_sticky) begin
            sticky <= 2'b00;
        end else if (pop) begin
            sticky <= sticky | {flags[1], flags[0]};
        end
    end
`endif

endmodule

// File: tb/tb_alu64bit_wb.sv
// Directed bench for alu64bit_wb: drivers push expected {res,flags} into a queue, a negedge monitor pops and compares.
// Build with ALU64BIT_WB_STICKY_EN defined to also exercise the sticky flags.
module tb_alu64bit_wb;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] s;
    logic         cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [3:0]   flags;
`ifdef ALU64BIT_WB_STICKY_EN
    logic         clr_sticky;
    logic [1:0]   sticky;
`endif

    logic [W+3:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    alu64bit_wb #(.WIDTH(W), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
`ifdef ALU64BIT_WB_STICKY_EN
        ,
        .clr_sticky(clr_sticky),
        .sticky    (sticky)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: holds the vector until accepted, recording the expected entry at acceptance.
    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [1:0] vop,
                         input logic [W-1:0] vs, input logic vc, input logic [3:0] vflags);
        bit done = 0;
        in_valid = 1'b1;
        a = va; b = vb; op = vop; s = vs; cout = vc;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({vs, vflags});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL drive_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain", W'(exp_q.size()), '0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got %h/%b, expected no output", res, flags);
            end else begin
                check("pop", {res, flags}, exp_q.pop_front());
            end
        end
    end

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = 64'd1;
    localparam logic [W-1:0] R1   = 64'h1111_2222_3333_4444;
    localparam logic [W-1:0] R2   = 64'h8888_0000_0000_0001;
    localparam logic [W-1:0] R3   = 64'h0000_0000_0000_0333;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 2'b00; s = '0; cout = 1'b0;
`ifdef ALU64BIT_WB_STICKY_EN
        clr_sticky = 1'b0;
`endif
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), '0);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_res_flags", {res, flags}, '0);
`ifdef ALU64BIT_WB_STICKY_EN
        check("rst_sticky", W'(sticky), '0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", W'(in_ready), W'(1));
        check("rel_out_valid", W'(out_valid), '0);
        @(posedge clk);
        #1;

        // Flag vectors with one-cycle latency
        out_ready = 1'b1;
        drive(ONES - 64'd1, ONE, 2'b10, ONES, 1'b0, 4'b0100);
        check("lat_out_valid", W'(out_valid), W'(1));
        check("lat_head", {res, flags}, {ONES, 4'b0100});
        drive(ONES, ONE, 2'b10, '0, 1'b1, 4'b1010);
        drive(MAXP, ONE, 2'b10, MINN, 1'b0, 4'b0101);
        drive(MAXP, ONE, 2'b01, MINN, 1'b0, 4'b0100);
        drive(MINN, ONE, 2'b11, MAXP, 1'b1, 4'b0011);
        drive(ONES, ONES, 2'b00, '0, 1'b1, 4'b1000);
        drive(MINN, MINN, 2'b10, '0, 1'b1, 4'b1011);
        wait_empty();

        // Backpressure: two entries fill the buffer, a third is refused
        out_ready = 1'b0;
        drive('0, '0, 2'b01, R1, 1'b0, 4'b0000);
        drive('0, '0, 2'b01, R2, 1'b0, 4'b0100);
        check("full_in_ready", W'(in_ready), '0);
        in_valid = 1'b1; a = '0; b = '0; op = 2'b01; s = R3; cout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", W'(in_ready), '0);
            check("stall_head", {res, flags}, {R1, 4'b0000});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("after_pop_in_ready", W'(in_ready), W'(1));
        check("after_pop_head", {res, flags}, {R2, 4'b0100});
        wait_empty();

        // Simultaneous push and pop at count=1
        out_ready = 1'b0;
        drive('0, '0, 2'b01, R1, 1'b0, 4'b0000);
        out_ready = 1'b1;
        drive('0, '0, 2'b01, R3, 1'b0, 4'b0000);
        check("pp_out_valid", W'(out_valid), W'(1));
        check("pp_in_ready", W'(in_ready), W'(1));
        check("pp_head", {res, flags}, {R3, 4'b0000});
        wait_empty();

        // Reset with a full buffer discards both entries
        out_ready = 1'b0;
        drive('0, '0, 2'b01, R1, 1'b0, 4'b0000);
        drive('0, '0, 2'b01, R2, 1'b0, 4'b0100);
        check("pre_rst_full", W'(in_ready), '0);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_out_valid", W'(out_valid), '0);
        check("mid_rst_res_flags", {res, flags}, '0);
        check("mid_rst_in_ready", W'(in_ready), '0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", W'(in_ready), W'(1));
        check("post_rst_out_valid", W'(out_valid), '0);
        @(posedge clk);
        #1;
        drive(ONES, ONE, 2'b10, '0, 1'b1, 4'b1010);
        wait_empty();

`ifdef ALU64BIT_WB_STICKY_EN
        // Sticky flags accumulate on pops; clear beats a same-cycle set
        drive(MAXP, ONE, 2'b10, MINN, 1'b0, 4'b0101);
        wait_empty();
        tick();
        check("sticky_v", W'(sticky), W'(2'b01));
        drive(ONES, ONE, 2'b10, '0, 1'b1, 4'b1010);
        wait_empty();
        tick();
        check("sticky_cv", W'(sticky), W'(2'b11));
        out_ready = 1'b0;
        drive(MAXP, ONE, 2'b10, MINN, 1'b0, 4'b0101);
        out_ready = 1'b1;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("sticky_clr", W'(sticky), '0);
        wait_empty();
`endif

        out_ready = 1'b0;
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
